// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter (plus gate leaves and8, or8, xor8, nor8,
//            nand8, xnor8, not8)
// Purpose  : Shares one bitwise logic unit between two requesters
//            (0: ALU path, 1: mask/address path). Round-robin grant,
//            operand capture, registered result on a single response
//            channel tagged with the owning requester.
// Ports    : clk, rst            clock, synchronous active-high reset
//            req_valid[1:0]      per-requester request valid
//            req_ready[1:0]      per-requester accept (one-hot or zero)
//            req{0,1}_op/a/b     per-requester opcode and operands
//            rsp_valid/rsp_ready response handshake
//            rsp_id, rsp_y       owning requester, result
//            rsp_zero/rsp_parity result flags
// Macro    : LOGIC_ARB_FLAGS_EN  registers rsp_zero/rsp_parity; when not
//            defined both flags are tied 0 (ports kept).
// Revision : 1.0  initial release
// ============================================================================

module and8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module or8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a | b;
endmodule

module xor8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

module nor8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a | b);
endmodule

module nand8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a & b);
endmodule

module xnor8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a ^ b);
endmodule

module not8 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH   = 8,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_parity
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_prio;
  logic             r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;

  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_xnor;
  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_result;

  // Contention goes to the priority holder; a lone requester simply wins.
  assign w_grant  = (req_valid == 2'b11) ? r_prio : req_valid[1];
  // Reset masks the accept so nothing is handshaken in a reset cycle.
  assign w_accept = (r_state == ST_IDLE) && (|req_valid) && !rst;
  assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  and8  #(.WIDTH(WIDTH)) u_and  (.a(r_a), .b(r_b), .y(w_and));
  or8   #(.WIDTH(WIDTH)) u_or   (.a(r_a), .b(r_b), .y(w_or));
  xor8  #(.WIDTH(WIDTH)) u_xor  (.a(r_a), .b(r_b), .y(w_xor));
  nor8  #(.WIDTH(WIDTH)) u_nor  (.a(r_a), .b(r_b), .y(w_nor));
  nand8 #(.WIDTH(WIDTH)) u_nand (.a(r_a), .b(r_b), .y(w_nand));
  xnor8 #(.WIDTH(WIDTH)) u_xnor (.a(r_a), .b(r_b), .y(w_xnor));
  not8  #(.WIDTH(WIDTH)) u_not  (.a(r_a), .y(w_not));

  always_comb begin
    w_result = r_a;
    case (r_op)
      3'b000:  w_result = w_and;
      3'b001:  w_result = w_or;
      3'b010:  w_result = w_xor;
      3'b011:  w_result = w_nor;
      3'b100:  w_result = w_nand;
      3'b101:  w_result = w_xnor;
      3'b110:  w_result = w_not;
      default: w_result = r_a;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_prio   <= 1'(RR_INIT);
      r_id     <= 1'b0;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_rsp_id <= 1'b0;
      r_rsp_y  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id   <= w_grant;
        r_op   <= w_grant ? req1_op : req0_op;
        r_a    <= w_grant ? req1_a  : req0_a;
        r_b    <= w_grant ? req1_b  : req0_b;
        r_prio <= ~w_grant;
      end
      // The response id is loaded with the result so it never changes
      // under an in-flight response when the next request is captured.
      if (r_state == ST_EXEC) begin
        r_rsp_y  <= w_result;
        r_rsp_id <= r_id;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;

`ifdef LOGIC_ARB_FLAGS_EN
  logic r_zero;
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_zero   <= (w_result == '0);
      r_parity <= ^w_result;
    end
  end

  assign rsp_zero   = r_zero;
  assign rsp_parity = r_parity;
`else
  assign rsp_zero   = 1'b0;
  assign rsp_parity = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Purpose  : Directed self-checking bench for logic_unit_arbiter
//            (RR_INIT = 0, WIDTH = 8). Honours LOGIC_ARB_FLAGS_EN.
// Revision : 1.0  initial release
// ============================================================================

module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [2:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_y;
  logic       rsp_zero;
  logic       rsp_parity;

  int total = 0;
  int bad   = 0;

  logic flags_on;

  logic_unit_arbiter #(.WIDTH(8), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_parity(rsp_parity)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_op = 3'b000; req0_a = 8'h0F; req0_b = 8'hF0;
    req1_op = 3'b001; req1_a = 8'h0F; req1_b = 8'hF0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready cyc%0d got=%b exp=00", c, req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid cyc%0d got=%b exp=0", c, rsp_valid); end
      total++; if (rsp_y !== 8'h00) begin bad++; $display("FAIL reset_rsp_y cyc%0d got=%h exp=00", c, rsp_y); end
    end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_exec_valid got=%b exp=0", rsp_valid); end
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_y !== 8'h00) begin
      bad++; $display("FAIL reset_first_rsp got v=%b id=%b y=%h exp v=1 id=0 y=00", rsp_valid, rsp_id, rsp_y);
    end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_back_idle got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_single();
    // prio now 1, but only requester 0 asks
    req0_op = 3'b000; req0_a = 8'h0F; req0_b = 8'hF0;
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_exec got ready=%b v=%b exp ready=00 v=0", req_ready, rsp_valid);
    end
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_y !== 8'h00) begin
      bad++; $display("FAIL single_rsp got v=%b id=%b y=%h exp v=1 id=0 y=00", rsp_valid, rsp_id, rsp_y);
    end
    total++; if (rsp_zero !== flags_on || rsp_parity !== 1'b0) begin
      bad++; $display("FAIL single_flags got z=%b p=%b exp z=%b p=0", rsp_zero, rsp_parity, flags_on);
    end
    step();
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] exp_y [8];
    exp_y[0] = 8'h00; exp_y[1] = 8'hFF; exp_y[2] = 8'hFF; exp_y[3] = 8'h00;
    exp_y[4] = 8'hFF; exp_y[5] = 8'h00; exp_y[6] = 8'h55; exp_y[7] = 8'hAA;
    req1_a = 8'hAA; req1_b = 8'h55;
    for (int i = 0; i < 8; i++) begin
      req1_op = 3'(i);
      req_valid = 2'b10;
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL sweep_ready op%0d got=%b exp=10", i, req_ready); end
      step();
      req_valid = 2'b00;
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_y !== exp_y[i]) begin
        bad++; $display("FAIL sweep_rsp op%0d got v=%b id=%b y=%h exp v=1 id=1 y=%h", i, rsp_valid, rsp_id, rsp_y, exp_y[i]);
      end
      // every expected result here has even parity
      total++; if (rsp_zero !== (flags_on && exp_y[i] == 8'h00) || rsp_parity !== 1'b0) begin
        bad++; $display("FAIL sweep_flags op%0d got z=%b p=%b exp z=%b p=0", i, rsp_zero, rsp_parity, flags_on && exp_y[i] == 8'h00);
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_y;
    logic       g;
    // 0x3C ^ 0x0F = 0x33 ; 0x3C | 0x0F = 0x3F
    req0_op = 3'b010; req0_a = 8'h3C; req0_b = 8'h0F;
    req1_op = 3'b001; req1_a = 8'h3C; req1_b = 8'h0F;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp_y = g ? 8'h3F : 8'h33;
      #1;
      total++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL contention_grant op%0d got=%b exp=%b", k, req_ready, g ? 2'b10 : 2'b01);
      end
      step();
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL contention_exec_ready op%0d got=%b exp=00", k, req_ready); end
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== g || rsp_y !== exp_y) begin
        bad++; $display("FAIL contention_rsp op%0d got v=%b id=%b y=%h exp v=1 id=%b y=%h", k, rsp_valid, rsp_id, rsp_y, g, exp_y);
      end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    // prio is 0 here; 0xF0 nand 0x3C = 0xCF
    req0_op = 3'b100; req0_a = 8'hF0; req0_b = 8'h3C;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b10;
    step();
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_y !== 8'hCF) begin
        bad++; $display("FAIL bp_hold cyc%0d got v=%b id=%b y=%h exp v=1 id=0 y=cf", c, rsp_valid, rsp_id, rsp_y);
      end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready cyc%0d got=%b exp=00", c, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_idle_accept got=%b exp=10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    // reset while in EXEC
    req1_op = 3'b010; req1_a = 8'hFF; req1_b = 8'h0F;
    req_valid = 2'b10;
    #1;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL rst_exec got v=%b y=%h id=%b exp v=0 y=00 id=0", rsp_valid, rsp_y, rsp_id);
    end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_exec_lost got=%b exp=0", rsp_valid); end
    // reset while in RESP; requester 0 served so prio would become 1
    req0_op = 3'b010; req0_a = 8'hFF; req0_b = 8'h0F;
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_y !== 8'hF0 || rsp_id !== 1'b0) begin
      bad++; $display("FAIL rst_resp_pre got v=%b y=%h id=%b exp v=1 y=f0 id=0", rsp_valid, rsp_y, rsp_id);
    end
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_cycle_ready got=%b exp=00", req_ready); end
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    total++; if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_zero !== 1'b0 || rsp_parity !== 1'b0) begin
      bad++; $display("FAIL rst_resp got v=%b y=%h z=%b p=%b exp all 0", rsp_valid, rsp_y, rsp_zero, rsp_parity);
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_prio got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    step();
  endtask

  task automatic test_operand_capture();
    // 0xF0 & 0x3C = 0x30 even though operands change after the accept
    req0_op = 3'b000; req0_a = 8'hF0; req0_b = 8'h3C;
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    req0_op = 3'b111; req0_a = 8'h00; req0_b = 8'h00;
    step();
    total++; if (rsp_valid !== 1'b1 || rsp_y !== 8'h30) begin
      bad++; $display("FAIL capture got v=%b y=%h exp v=1 y=30", rsp_valid, rsp_y);
    end
    step();
  endtask

  initial begin
`ifdef LOGIC_ARB_FLAGS_EN
    flags_on = 1'b1;
`else
    flags_on = 1'b0;
`endif
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
    req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
    test_reset();
    test_single();
    test_opcode_sweep();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_operand_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
